// File: rtl/unigate_pkg.sv
// Shared constants for the unigate config loader: register offsets, control/status
// bit positions, FSM state encodings and the INFO version byte.
package unigate_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_INFO = 2'd3;

  localparam int CTRL_LATCH_BIT  = 0;
  localparam int CTRL_CLRCNT_BIT = 1;
  localparam int STAT_OVR_BIT    = 31;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  localparam logic [7:0] INFO_VER = 8'h01;

  function automatic logic [31:0] stat_word(input logic ovr, input logic busy,
                                            input logic [15:0] words);
    return {ovr, busy, 14'b0, words};
  endfunction

endpackage

// File: rtl/unigate_wb_regif.sv
// Wishbone slave front end: address decode, single-cycle registered ack, read mux
// and full-word write strobes toward the sequencer.
module unigate_wb_regif
  import unigate_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_wr_data,
  output logic        o_wr_ctrl,
  output logic        o_wr_stat,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rd_data,
  input  logic [31:0] i_rd_stat,
  input  logic [31:0] i_rd_info
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_hit;
  logic        w_wr;
  logic [1:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_off    = wbs_adr_i[3:2];
  assign w_unused = ^wbs_adr_i[1:0];

  // The !r_ack term keeps a held strobe from producing back-to-back hits.
  assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
  assign w_wr  = w_hit & wbs_we_i & (wbs_sel_i == 4'hF);

  assign o_wr_data = w_wr & (w_off == REG_DATA);
  assign o_wr_ctrl = w_wr & (w_off == REG_CTRL);
  assign o_wr_stat = w_wr & (w_off == REG_STAT);
  assign o_wdata   = wbs_dat_i;

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      REG_DATA: w_rdata = i_rd_data;
      REG_STAT: w_rdata = i_rd_stat;
      REG_INFO: w_rdata = i_rd_info;
      default:  w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_hit;
      r_dat <= (w_hit & ~wbs_we_i) ? w_rdata : 32'h0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule

// File: rtl/unigate_cfg_loader.sv
// Config sequencer: shifts each written word MSB-first into the fabric chain
// (two clocks per bit) and pulses the latch strobe on command.
module unigate_cfg_loader
  import unigate_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          LATCH_CYC = 4,
  parameter int          CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_sclk_o,
  output logic        cfg_sdata_o,
  output logic        cfg_latch_o,
  output logic        cfg_busy_o,
  output logic        irq_o
);

  localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  logic [1:0]       r_state;
  logic [31:0]      r_shreg;
  logic [4:0]       r_bitcnt;
  logic [LW-1:0]    r_latcnt;
  logic [CNT_W-1:0] r_words;
  logic             r_ovr;
  logic [31:0]      r_last;
  logic             r_sclk, r_sdata, r_latch, r_busy, r_irq;

  logic        w_wr_data, w_wr_ctrl, w_wr_stat;
  logic [31:0] w_wdata;
  logic        w_idle, w_load, w_latch_go, w_clr, w_ovr_set, w_inc;
  logic [1:0]       w_state_nxt;
  logic [31:0]      w_shreg_nxt;
  logic [4:0]       w_bitcnt_nxt;
  logic [LW-1:0]    w_latcnt_nxt;
  logic [31:0]      w_rd_stat, w_rd_info;

  unigate_wb_regif #(.BASE_ADDR(BASE_ADDR)) u_regif (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .o_wr_data (w_wr_data),
    .o_wr_ctrl (w_wr_ctrl),
    .o_wr_stat (w_wr_stat),
    .o_wdata   (w_wdata),
    .i_rd_data (r_last),
    .i_rd_stat (w_rd_stat),
    .i_rd_info (w_rd_info)
  );

  assign w_rd_stat = stat_word(r_ovr, r_busy, 16'(r_words));
  assign w_rd_info = {16'h0, 8'(LATCH_CYC), INFO_VER};

  assign w_idle     = (r_state == ST_IDLE);
  assign w_load     = w_wr_data & w_idle;
  assign w_latch_go = w_wr_ctrl & w_idle & w_wdata[CTRL_LATCH_BIT];
  assign w_clr      = w_wr_ctrl & w_idle & w_wdata[CTRL_CLRCNT_BIT];
  assign w_ovr_set  = (w_wr_data | w_wr_ctrl) & ~w_idle;

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_latcnt_nxt = r_latcnt;
    w_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_shreg_nxt  = w_wdata;
          w_bitcnt_nxt = 5'd31;
          w_state_nxt  = ST_SHIFT_LO;
        end else if (w_latch_go) begin
          w_latcnt_nxt = LW'(LATCH_CYC - 1);
          w_state_nxt  = ST_LATCH;
        end
      end
      ST_SHIFT_LO: w_state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        w_shreg_nxt = {r_shreg[30:0], 1'b0};
        if (r_bitcnt == 5'd0) begin
          w_inc       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_bitcnt_nxt = r_bitcnt - 5'd1;
          w_state_nxt  = ST_SHIFT_LO;
        end
      end
      default: begin
        if (r_latcnt == '0) w_state_nxt = ST_IDLE;
        else                w_latcnt_nxt = r_latcnt - 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_shreg  <= 32'h0;
      r_bitcnt <= 5'd0;
      r_latcnt <= '0;
      r_words  <= '0;
      r_ovr    <= 1'b0;
      r_last   <= 32'h0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_latcnt <= w_latcnt_nxt;
      if (w_load) r_last <= w_wdata;
      if (w_clr) r_words <= '0;
      else if (w_inc && (r_words != {CNT_W{1'b1}})) r_words <= r_words + 1'b1;
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (w_wr_stat && w_wdata[STAT_OVR_BIT]) r_ovr <= 1'b0;
      r_sclk  <= (w_state_nxt == ST_SHIFT_HI);
      r_sdata <= ((w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI)) ?
                 w_shreg_nxt[31] : 1'b0;
      r_latch <= (w_state_nxt == ST_LATCH);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_irq   <= (r_state == ST_LATCH) && (w_state_nxt == ST_IDLE);
    end
  end

  assign cfg_sclk_o  = r_sclk;
  assign cfg_sdata_o = r_sdata;
  assign cfg_latch_o = r_latch;
  assign cfg_busy_o  = r_busy;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_unigate_cfg_loader.sv
// Directed bench for unigate_cfg_loader; CNT_W is shrunk to 2 so saturation is reachable.
module tb_unigate_cfg_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        ack, sclk, sdata, latch, busy, irq;
  logic [31:0] dat_o;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] mon_sr = 32'h0;
  int          mon_n  = 0;

  unigate_cfg_loader #(.BASE_ADDR(BASE), .LATCH_CYC(4), .CNT_W(2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .cfg_sclk_o  (sclk),
    .cfg_sdata_o (sdata),
    .cfg_latch_o (latch),
    .cfg_busy_o  (busy),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    mon_sr = {mon_sr[30:0], sdata};
    mon_n  = mon_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic ak);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    ak = ack; rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] rd;
    logic        ak;
    wb_acc(1'b1, a, d, s, rd, ak);
    chk({tag, "_ack"}, {31'h0, ak}, 32'h1);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ak;
    wb_acc(1'b0, a, 32'h0, 4'hF, rd, ak);
    chk({tag, "_ack"}, {31'h0, ak}, 32'h1);
    chk(tag, rd, exp);
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk({tag, "_timeout"}, 32'h1, 32'h0);
  endtask

  initial begin
    int n;
    int base;
    logic seen;

    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {26'h0, ack, sclk, sdata, latch, busy, irq}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    rst_n = 1'b1;
    rdchk("rst_stat", BASE + 32'h8, 32'h0000_0000);
    rdchk("rst_info", BASE + 32'hC, 32'h0000_0401);

    // 2. one word shifted out
    base = mon_n;
    wr("data1", BASE, 32'hA5A5_0F0F, 4'hF);
    chk("busy_start", {31'h0, busy}, 32'h1);
    wait_idle("shift1", n);
    chk("busy_cycles", n, 64);
    chk("rise_count", mon_n - base, 32);
    chk("stream1", mon_sr, 32'hA5A5_0F0F);
    rdchk("stat_w1", BASE + 32'h8, 32'h0000_0001);
    rdchk("data_rb", BASE, 32'hA5A5_0F0F);
    @(posedge clk); #1;
    chk("dat_o_idle", dat_o, 32'h0);

    // 3. latch strobe
    wr("latch", BASE + 32'h4, 32'h1, 4'hF);
    chk("latch_hi", {30'h0, latch, busy}, 32'h3);
    n = 0;
    while (latch && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latch_cycles", n, 4);
    chk("irq_pulse", {30'h0, irq, busy}, 32'h2);
    @(posedge clk); #1;
    chk("irq_clear", {31'h0, irq}, 32'h0);
    rdchk("ctrl_rd", BASE + 32'h4, 32'h0);

    // 4. overrun mid-shift
    base = mon_n;
    wr("data2", BASE, 32'h1234_5678, 4'hF);
    repeat (10) begin
      @(posedge clk); #1;
    end
    wr("data_ovr", BASE, 32'hFFFF_FFFF, 4'hF);
    rdchk("stat_mid", BASE + 32'h8, 32'hC000_0001);
    wait_idle("shift2", n);
    chk("rise_count2", mon_n - base, 32);
    chk("stream2", mon_sr, 32'h1234_5678);
    rdchk("data_kept", BASE, 32'h1234_5678);
    rdchk("stat_ovr", BASE + 32'h8, 32'h8000_0002);
    wr("ovr_clr", BASE + 32'h8, 32'h8000_0000, 4'hF);
    rdchk("stat_clr", BASE + 32'h8, 32'h0000_0002);

    // 5. partial select ignored, out-of-window never acked
    wr("sel3", BASE, 32'hDEAD_BEEF, 4'h3);
    chk("sel3_nobusy", {31'h0, busy}, 32'h0);
    rdchk("sel3_data", BASE, 32'h1234_5678);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("miss_noack", {31'h0, seen}, 32'h0);

    // latch + clear together, then saturate the 2-bit counter
    wr("latch_clr", BASE + 32'h4, 32'h3, 4'hF);
    chk("lc_latch", {31'h0, latch}, 32'h1);
    wait_idle("lc", n);
    rdchk("stat_cleared", BASE + 32'h8, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wr("sat_data", BASE, 32'h8000_0001 + i, 4'hF);
      wait_idle("sat", n);
    end
    rdchk("stat_sat", BASE + 32'h8, 32'h0000_0003);

    // 6. async reset at bit 10
    base = mon_n;
    wr("data3", BASE, 32'h0F0F_F0F0, 4'hF);
    n = 0;
    while ((mon_n - base) < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bit10_reached", {31'h0, (mon_n - base) == 10}, 32'h1);
    chk("pre_rst_busy", {30'h0, sclk, busy}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {29'h0, sclk, sdata, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdchk("post_rst_stat", BASE + 32'h8, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
